rtm_wr_ctrl: RTL and testbench

- RTM write-side arbiter; the counterpart of the RTM read controller.
- Five write clients compete for the shared RTM write ports: DRAM load, PPU (conv output), Fc, Add and Remap.
- Fixed-priority arbitration with per-client burst lock, so a burst lands contiguously.
- Registered port drive, plus a per-client done pulse once the burst's last write is visible to readers.

---
 rtl/rtm_wr_ctrl_pkg.sv | 25 ++
 rtl/rtm_wr_arb.sv | 48 ++++
 rtl/shift_reg.sv | 26 ++
 rtl/rtm_wr_ctrl.sv | 135 +++++++++++++
 tb/tb_rtm_wr_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtm_wr_ctrl_pkg.sv
// Shared constants for the RTM write-side controller: geometry defaults,
// client indices and the fixed-priority pick used by the arbiter.
package rtm_wr_ctrl_pkg;

    localparam int RTM_S             = 2;
    localparam int RTM_R             = 2;
    localparam int RTM_DEPTH         = 64;
    localparam int RTM_URAM_NUM_PIPE = 2;

    localparam int NUM_WR_CLIENTS = 5;
    localparam int CL_DRAM        = 0;
    localparam int CL_PPU         = 1;
    localparam int CL_FC          = 2;
    localparam int CL_ADD         = 3;
    localparam int CL_REMAP       = 4;

    // Lowest index wins, so client numbering doubles as priority order.
    function automatic logic [2:0] prio_idx(input logic [NUM_WR_CLIENTS-1:0] req);
        prio_idx = 3'd0;
        for (int i = NUM_WR_CLIENTS - 1; i >= 0; i--) begin
            if (req[i]) prio_idx = 3'(i);
        end
    endfunction

endpackage

// File: rtl/rtm_wr_arb.sv
// Fixed-priority write arbiter with burst lock: the owner of an open burst
// keeps the port until its last beat, whatever higher-priority clients want.
module rtm_wr_arb
    import rtm_wr_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_WR_CLIENTS-1:0] i_vld,
    input  logic [NUM_WR_CLIENTS-1:0] i_last,
    output logic [NUM_WR_CLIENTS-1:0] o_grant,
    output logic [2:0]                o_gidx
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_LOCK = 1'b1;

    logic       r_state;
    logic [2:0] r_owner;

    // NOTE: o_grant is cleared first so every path assigns it and no latch is inferred.
    always_comb begin
        o_grant = '0;
        o_gidx  = prio_idx(i_vld);
        if (rst_n) begin
            if (r_state == ST_LOCK) begin
                o_gidx           = r_owner;
                o_grant[r_owner] = i_vld[r_owner];
            end else if (|i_vld) begin
                o_grant[o_gidx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
        end else if (|o_grant) begin
            if (i_last[o_gidx]) begin
                r_state <= ST_IDLE;
            end else begin
                r_state <= ST_LOCK;
                r_owner <= o_gidx;
            end
        end
    end

endmodule

// File: rtl/shift_reg.sv
// Fixed-length shift register with synchronous active-low reset.
module shift_reg #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    // NOTE: every stage is reset, not just the output, so a pulse in flight cannot surface after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/rtm_wr_ctrl.sv
// RTM write-side controller: arbitrates five clients onto the shared RTM
// write port and pulses a per-client done once a burst is read-visible.
module rtm_wr_ctrl
    import rtm_wr_ctrl_pkg::*;
#(
    parameter int S      = RTM_S,
    parameter int R      = RTM_R,
    parameter int DEPTH  = RTM_DEPTH,
    parameter int WR_LAT = RTM_URAM_NUM_PIPE + 1,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_vld_dram,
    input  logic              wr_last_dram,
    input  logic [S-1:0]      wr_en_dram,
    input  logic [S*AW-1:0]   wr_addr_dram,
    input  logic [S*R*8-1:0]  wr_din_dram,
    output logic              wr_rdy_dram,
    output logic              wr_done_dram,
    input  logic              wr_vld_ppu,
    input  logic              wr_last_ppu,
    input  logic [S-1:0]      wr_en_ppu,
    input  logic [S*AW-1:0]   wr_addr_ppu,
    input  logic [S*R*8-1:0]  wr_din_ppu,
    output logic              wr_rdy_ppu,
    output logic              wr_done_ppu,
    input  logic              wr_vld_fc,
    input  logic              wr_last_fc,
    input  logic [S-1:0]      wr_en_fc,
    input  logic [S*AW-1:0]   wr_addr_fc,
    input  logic [S*R*8-1:0]  wr_din_fc,
    output logic              wr_rdy_fc,
    output logic              wr_done_fc,
    input  logic              wr_vld_add,
    input  logic              wr_last_add,
    input  logic [S-1:0]      wr_en_add,
    input  logic [S*AW-1:0]   wr_addr_add,
    input  logic [S*R*8-1:0]  wr_din_add,
    output logic              wr_rdy_add,
    output logic              wr_done_add,
    input  logic              wr_vld_remap,
    input  logic              wr_last_remap,
    input  logic [S-1:0]      wr_en_remap,
    input  logic [S*AW-1:0]   wr_addr_remap,
    input  logic [S*R*8-1:0]  wr_din_remap,
    output logic              wr_rdy_remap,
    output logic              wr_done_remap,
    output logic [S-1:0]      wr_en,
    output logic [S*AW-1:0]   wr_addr,
    output logic [S*R*8-1:0]  din
);

    logic [NUM_WR_CLIENTS-1:0] w_vld;
    logic [NUM_WR_CLIENTS-1:0] w_last;
    logic [NUM_WR_CLIENTS-1:0] w_grant;
    logic [NUM_WR_CLIENTS-1:0] w_done;
    logic [2:0]                w_sel;
    logic [S-1:0]              w_en   [NUM_WR_CLIENTS];
    logic [S*AW-1:0]           w_addr [NUM_WR_CLIENTS];
    logic [S*R*8-1:0]          w_din  [NUM_WR_CLIENTS];

    logic [S-1:0]              r_en;
    logic [S*AW-1:0]           r_addr;
    logic [S*R*8-1:0]          r_din;

    assign w_vld  = {wr_vld_remap, wr_vld_add, wr_vld_fc, wr_vld_ppu, wr_vld_dram};
    assign w_last = {wr_last_remap, wr_last_add, wr_last_fc, wr_last_ppu, wr_last_dram};

    assign w_en[CL_DRAM]    = wr_en_dram;
    assign w_en[CL_PPU]     = wr_en_ppu;
    assign w_en[CL_FC]      = wr_en_fc;
    assign w_en[CL_ADD]     = wr_en_add;
    assign w_en[CL_REMAP]   = wr_en_remap;
    assign w_addr[CL_DRAM]  = wr_addr_dram;
    assign w_addr[CL_PPU]   = wr_addr_ppu;
    assign w_addr[CL_FC]    = wr_addr_fc;
    assign w_addr[CL_ADD]   = wr_addr_add;
    assign w_addr[CL_REMAP] = wr_addr_remap;
    assign w_din[CL_DRAM]   = wr_din_dram;
    assign w_din[CL_PPU]    = wr_din_ppu;
    assign w_din[CL_FC]     = wr_din_fc;
    assign w_din[CL_ADD]    = wr_din_add;
    assign w_din[CL_REMAP]  = wr_din_remap;

    rtm_wr_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_vld   (w_vld),
        .i_last  (w_last),
        .o_grant (w_grant),
        .o_gidx  (w_sel)
    );

    // Address and data hold when idle; only the enable drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_en   <= '0;
            r_addr <= '0;
            r_din  <= '0;
        end else if (|w_grant) begin
            r_en   <= w_en[w_sel];
            r_addr <= w_addr[w_sel];
            r_din  <= w_din[w_sel];
        end else begin
            r_en   <= '0;
        end
    end

    shift_reg #(
        .WIDTH (NUM_WR_CLIENTS),
        .DEPTH (1 + WR_LAT)
    ) u_done_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_grant & w_last),
        .o_q   (w_done)
    );

    assign wr_en   = r_en;
    assign wr_addr = r_addr;
    assign din     = r_din;

    assign wr_rdy_dram   = w_grant[CL_DRAM];
    assign wr_rdy_ppu    = w_grant[CL_PPU];
    assign wr_rdy_fc     = w_grant[CL_FC];
    assign wr_rdy_add    = w_grant[CL_ADD];
    assign wr_rdy_remap  = w_grant[CL_REMAP];
    assign wr_done_dram  = w_done[CL_DRAM];
    assign wr_done_ppu   = w_done[CL_PPU];
    assign wr_done_fc    = w_done[CL_FC];
    assign wr_done_add   = w_done[CL_ADD];
    assign wr_done_remap = w_done[CL_REMAP];

endmodule

// File: tb/tb_rtm_wr_ctrl.sv
// Self-checking bench for rtm_wr_ctrl: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the arbitration rules.
module tb_rtm_wr_ctrl;
    import rtm_wr_ctrl_pkg::*;

    localparam int S      = RTM_S;
    localparam int R      = RTM_R;
    localparam int AW     = $clog2(RTM_DEPTH);
    localparam int WR_LAT = RTM_URAM_NUM_PIPE + 1;
    localparam int NC     = NUM_WR_CLIENTS;
    localparam int AWS    = S * AW;
    localparam int DW     = S * R * 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NC-1:0]  vld, last;
    logic [S-1:0]   en    [NC];
    logic [AWS-1:0] addr  [NC];
    logic [DW-1:0]  din_c [NC];
    wire  [NC-1:0]  rdy, done;
    wire  [S-1:0]   wr_en;
    wire  [AWS-1:0] wr_addr;
    wire  [DW-1:0]  din;

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural model: owner of the open burst (-1 = none), expected port, done schedule.
    int             m_owner;
    logic [S-1:0]   m_en;
    logic [AWS-1:0] m_addr;
    logic [DW-1:0]  m_din;
    logic [NC-1:0]  m_done;
    logic [NC-1:0]  due [64];
    int             k;

    always #5 clk = ~clk;

    rtm_wr_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .wr_vld_dram(vld[0]),  .wr_last_dram(last[0]),  .wr_en_dram(en[0]),  .wr_addr_dram(addr[0]),  .wr_din_dram(din_c[0]),
        .wr_rdy_dram(rdy[0]),  .wr_done_dram(done[0]),
        .wr_vld_ppu(vld[1]),   .wr_last_ppu(last[1]),   .wr_en_ppu(en[1]),   .wr_addr_ppu(addr[1]),   .wr_din_ppu(din_c[1]),
        .wr_rdy_ppu(rdy[1]),   .wr_done_ppu(done[1]),
        .wr_vld_fc(vld[2]),    .wr_last_fc(last[2]),    .wr_en_fc(en[2]),    .wr_addr_fc(addr[2]),    .wr_din_fc(din_c[2]),
        .wr_rdy_fc(rdy[2]),    .wr_done_fc(done[2]),
        .wr_vld_add(vld[3]),   .wr_last_add(last[3]),   .wr_en_add(en[3]),   .wr_addr_add(addr[3]),   .wr_din_add(din_c[3]),
        .wr_rdy_add(rdy[3]),   .wr_done_add(done[3]),
        .wr_vld_remap(vld[4]), .wr_last_remap(last[4]), .wr_en_remap(en[4]), .wr_addr_remap(addr[4]), .wr_din_remap(din_c[4]),
        .wr_rdy_remap(rdy[4]), .wr_done_remap(done[4]),
        .wr_en(wr_en), .wr_addr(wr_addr), .din(din)
    );

    function automatic int model_grant();
        if (!rst_n) return -1;
        if (m_owner >= 0) return vld[m_owner] ? m_owner : -1;
        for (int i = 0; i < NC; i++) if (vld[i]) return i;
        return -1;
    endfunction

    function automatic logic [NC-1:0] grant_vec();
        int g;
        g = model_grant();
        return (g < 0) ? '0 : (NC'(1) << g);
    endfunction

    function automatic logic [AWS-1:0] rep(input int a);
        logic [AWS-1:0] v;
        for (int b = 0; b < S; b++) v[b*AW +: AW] = AW'(a);
        return v;
    endfunction

    function automatic logic [DW-1:0] din_of(input int c, input int a);
        return DW'(32'h5A00_0000 ^ (c << 16) ^ (a * 32'h0000_0103));
    endfunction

    // Advance the model by the coming clock edge, using the inputs now applied.
    task automatic model_step();
        int g;
        if (!rst_n) begin
            m_owner = -1; m_en = '0; m_addr = '0; m_din = '0; m_done = '0;
            for (int i = 0; i < 64; i++) due[i] = '0;
        end else begin
            g = model_grant();
            m_done = due[k % 64];
            due[k % 64] = '0;
            if (g >= 0) begin
                m_en = en[g]; m_addr = addr[g]; m_din = din_c[g];
                if (last[g]) begin
                    m_owner = -1;
                    due[(k + WR_LAT) % 64][g] = 1'b1;
                end else begin
                    m_owner = g;
                end
            end else begin
                m_en = '0;
            end
        end
        k++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        vld = '0; last = '0;
        for (int c = 0; c < NC; c++) begin en[c] = '0; addr[c] = '0; din_c[c] = '0; end
    endtask

    task automatic beat(input int c, input logic l, input int a);
        vld[c] = 1'b1; last[c] = l; en[c] = '1; addr[c] = rep(a); din_c[c] = din_of(c, a);
    endtask

    task automatic drain();
        clear_in();
        repeat (WR_LAT + 3) tick();
    endtask

    task automatic test_reset();
        clear_in();
        vld = '1; last = '1;
        for (int c = 0; c < NC; c++) en[c] = '1;
        #1;
        n_chk++; if (rdy !== '0) begin n_fail++; $display("FAIL reset_rdy_async: got %b want 0", rdy); end
        repeat (2) tick();
        n_chk++; if (rdy !== '0) begin n_fail++; $display("FAIL reset_rdy: got %b want 0", rdy); end
        n_chk++; if (wr_en !== '0) begin n_fail++; $display("FAIL reset_wr_en: got %h want 0", wr_en); end
        n_chk++; if (wr_addr !== '0) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
        n_chk++; if (din !== '0) begin n_fail++; $display("FAIL reset_din: got %h want 0", din); end
        n_chk++; if (done !== '0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        clear_in();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        drain();
        beat(CL_DRAM, 1'b1, 5);
        #1;
        n_chk++; if (rdy !== 5'b00001) begin n_fail++; $display("FAIL single_rdy: got %b want 00001", rdy); end
        tick();
        clear_in();
        #1;
        n_chk++; if (wr_en !== '1) begin n_fail++; $display("FAIL single_wr_en: got %h want all ones", wr_en); end
        n_chk++; if (wr_addr !== rep(5)) begin n_fail++; $display("FAIL single_wr_addr: got %h want %h", wr_addr, rep(5)); end
        n_chk++; if (din !== din_of(CL_DRAM, 5)) begin n_fail++; $display("FAIL single_din: got %h want %h", din, din_of(CL_DRAM, 5)); end
        n_chk++; if (done[CL_DRAM] !== 1'b0) begin n_fail++; $display("FAIL single_done_c1: got %b want 0", done[CL_DRAM]); end
        for (int j = 2; j <= WR_LAT + 3; j++) begin
            tick();
            n_chk++;
            if (done[CL_DRAM] !== (j == 1 + WR_LAT)) begin
                n_fail++; $display("FAIL single_done_c%0d: got %b want %b", j, done[CL_DRAM], (j == 1 + WR_LAT));
            end
            if (j == 2) begin
                n_chk++; if (wr_en !== '0) begin n_fail++; $display("FAIL single_idle_en: got %h want 0", wr_en); end
                n_chk++; if (wr_addr !== rep(5)) begin n_fail++; $display("FAIL single_addr_hold: got %h want %h", wr_addr, rep(5)); end
            end
        end
    endtask

    task automatic test_priority();
        drain();
        beat(CL_DRAM, 1'b1, 1); beat(CL_FC, 1'b1, 2); beat(CL_REMAP, 1'b1, 3);
        #1;
        n_chk++; if (rdy !== 5'b00001) begin n_fail++; $display("FAIL prio_c0_rdy: got %b want 00001", rdy); end
        tick(); vld[CL_DRAM] = 1'b0; #1;
        n_chk++; if (rdy !== 5'b00100) begin n_fail++; $display("FAIL prio_c1_rdy: got %b want 00100", rdy); end
        n_chk++; if (wr_addr !== rep(1)) begin n_fail++; $display("FAIL prio_c1_addr: got %h want %h", wr_addr, rep(1)); end
        tick(); vld[CL_FC] = 1'b0; #1;
        n_chk++; if (rdy !== 5'b10000) begin n_fail++; $display("FAIL prio_c2_rdy: got %b want 10000", rdy); end
        n_chk++; if (wr_addr !== rep(2)) begin n_fail++; $display("FAIL prio_c2_addr: got %h want %h", wr_addr, rep(2)); end
        tick(); vld[CL_REMAP] = 1'b0; #1;
        n_chk++; if (wr_addr !== rep(3)) begin n_fail++; $display("FAIL prio_c3_addr: got %h want %h", wr_addr, rep(3)); end
    endtask

    task automatic test_lock();
        logic [NC-1:0] want_rdy [5] = '{5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b00001};
        drain();
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc < 4) beat(CL_REMAP, cyc == 3, 10 + cyc);
            else begin vld[CL_REMAP] = 1'b0; last[CL_REMAP] = 1'b0; end
            if (cyc == 2) beat(CL_DRAM, 1'b1, 40);
            if (cyc == 5) vld[CL_DRAM] = 1'b0;
            #1;
            if (cyc < 5) begin
                n_chk++; if (rdy !== want_rdy[cyc]) begin n_fail++; $display("FAIL lock_c%0d_rdy: got %b want %b", cyc, rdy, want_rdy[cyc]); end
            end
            if (cyc >= 1) begin
                n_chk++;
                if (wr_addr !== rep(cyc < 5 ? 9 + cyc : 40) || wr_en !== '1) begin
                    n_fail++; $display("FAIL lock_c%0d_out: got %h/%h want %h/all ones", cyc, wr_addr, wr_en, rep(cyc < 5 ? 9 + cyc : 40));
                end
            end
            tick();
        end
        clear_in();
    endtask

    task automatic test_gap();
        drain();
        beat(CL_PPU, 1'b0, 20); tick();
        beat(CL_PPU, 1'b0, 21); tick();
        for (int g = 0; g < 3; g++) begin
            vld[CL_PPU] = 1'b0;
            beat(CL_FC, 1'b1, 30);
            #1;
            n_chk++; if (rdy !== '0) begin n_fail++; $display("FAIL gap%0d_rdy: got %b want 0", g, rdy); end
            n_chk++;
            if (wr_en !== ((g == 0) ? '1 : '0)) begin
                n_fail++; $display("FAIL gap%0d_wr_en: got %h want %h", g, wr_en, (g == 0) ? '1 : '0);
            end
            tick();
        end
        beat(CL_PPU, 1'b1, 22);
        #1;
        n_chk++; if (rdy !== 5'b00010) begin n_fail++; $display("FAIL gap_resume_rdy: got %b want 00010", rdy); end
        tick();
        vld[CL_PPU] = 1'b0;
        #1;
        n_chk++; if (rdy !== 5'b00100) begin n_fail++; $display("FAIL gap_next_rdy: got %b want 00100", rdy); end
        n_chk++; if (wr_addr !== rep(22)) begin n_fail++; $display("FAIL gap_last_addr: got %h want %h", wr_addr, rep(22)); end
        tick();
        clear_in();
        #1;
        n_chk++; if (wr_addr !== rep(30)) begin n_fail++; $display("FAIL gap_fc_addr: got %h want %h", wr_addr, rep(30)); end
    endtask

    task automatic test_reset_mid();
        drain();
        beat(CL_ADD, 1'b1, 50);
        #1;
        n_chk++; if (rdy !== 5'b01000) begin n_fail++; $display("FAIL rmid_single_rdy: got %b want 01000", rdy); end
        tick();
        beat(CL_ADD, 1'b0, 51); tick();
        beat(CL_ADD, 1'b0, 52); tick();
        beat(CL_ADD, 1'b0, 53);
        rst_n = 1'b0;
        #1;
        n_chk++; if (rdy !== '0) begin n_fail++; $display("FAIL rmid_rdy_in_reset: got %b want 0", rdy); end
        tick();
        rst_n = 1'b1;
        clear_in();
        beat(CL_FC, 1'b1, 60);
        #1;
        n_chk++;
        if (wr_en !== '0 || wr_addr !== '0 || din !== '0 || done !== '0) begin
            n_fail++; $display("FAIL rmid_outputs: got en=%h addr=%h din=%h done=%b want all 0", wr_en, wr_addr, din, done);
        end
        n_chk++; if (rdy !== 5'b00100) begin n_fail++; $display("FAIL rmid_fc_rdy: got %b want 00100", rdy); end
        tick();
        clear_in();
        #1;
        n_chk++; if (wr_addr !== rep(60)) begin n_fail++; $display("FAIL rmid_fc_addr: got %h want %h", wr_addr, rep(60)); end
        for (int j = 0; j < WR_LAT + 4; j++) begin
            n_chk++; if (done[CL_ADD] !== 1'b0) begin n_fail++; $display("FAIL rmid_no_done_add_%0d: got 1 want 0", j); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        drain();
        for (int cyc = 0; cyc < WR_LAT + 6; cyc++) begin
            if (cyc < 3) beat(CL_ADD, 1'b1, 70 + cyc);
            else clear_in();
            #1;
            if (cyc < 3) begin
                n_chk++; if (rdy !== 5'b01000) begin n_fail++; $display("FAIL b2b_c%0d_rdy: got %b want 01000", cyc, rdy); end
            end
            n_chk++;
            if (done[CL_ADD] !== (cyc >= 1 + WR_LAT && cyc <= 3 + WR_LAT)) begin
                n_fail++; $display("FAIL b2b_c%0d_done: got %b want %b", cyc, done[CL_ADD], (cyc >= 1 + WR_LAT && cyc <= 3 + WR_LAT));
            end
            tick();
        end
    endtask

    task automatic test_random();
        int rem [NC];
        logic [NC-1:0] acc;
        for (int c = 0; c < NC; c++) rem[c] = 0;
        acc = '0;
        drain();
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NC; c++) begin
                if (acc[c]) begin
                    rem[c]--;
                    vld[c] = 1'b0;
                end
                if (!vld[c]) begin
                    if (rem[c] == 0 && $urandom_range(0, 5) == 0) rem[c] = $urandom_range(1, 4);
                    if (rem[c] > 0 && $urandom_range(0, 3) != 0) begin
                        vld[c] = 1'b1;
                        last[c] = (rem[c] == 1);
                        en[c] = S'($urandom);
                        addr[c] = AWS'($urandom);
                        din_c[c] = DW'($urandom);
                    end
                end
            end
            rst_n = ($urandom_range(0, 99) != 0);
            #1;
            n_chk++;
            if (rdy !== grant_vec() || wr_en !== m_en || wr_addr !== m_addr || din !== m_din || done !== m_done) begin
                n_fail++;
                $display("FAIL rand_%0d: got rdy=%b en=%h addr=%h din=%h done=%b want rdy=%b en=%h addr=%h din=%h done=%b",
                         n, rdy, wr_en, wr_addr, din, done, grant_vec(), m_en, m_addr, m_din, m_done);
            end
            acc = grant_vec();
            tick();
        end
        rst_n = 1'b1;
        clear_in();
    endtask

    initial begin
        m_owner = -1; m_en = '0; m_addr = '0; m_din = '0; m_done = '0; k = 0;
        for (int i = 0; i < 64; i++) due[i] = '0;
        clear_in();
        test_reset();
        test_single();
        test_priority();
        test_lock();
        test_gap();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
